// File: rtl/pong_match_ctrl.sv
// Match sequencer for a one-player pong game: start, centre, serve countdown,
// rally, scoring, post-point pause and game-over handling.
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int PAUSE_FRAMES = 90
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       frame_tick,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       reset_game,
  output logic       serve,
  output logic       serve_dir,
  output logic       sq_missed,
  output logic [3:0] score_p,
  output logic [3:0] score_ai,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > PAUSE_FRAMES) ? SERVE_FRAMES : PAUSE_FRAMES;
  localparam int CW = $clog2(MAX_FRAMES + 1);
  localparam logic [CW-1:0] SERVE_CNT = CW'(SERVE_FRAMES);
  localparam logic [CW-1:0] PAUSE_CNT = CW'(PAUSE_FRAMES);
  localparam logic [3:0]    WIN_CNT   = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_CENTRE     = 3'd1,
    S_SERVE_WAIT = 3'd2,
    S_RALLY      = 3'd3,
    S_POINT      = 3'd4,
    S_OVER       = 3'd5
  } state_t;

  state_t        cur, nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          start_prev, start_det;
  logic [3:0]    sp_nxt, sa_nxt, sp_inc, sa_inc;
  logic          dir_nxt, missed_nxt, win_nxt, serve_nxt, rg_nxt, go_nxt;

  assign state = cur;

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    start_det  = start_btn & ~start_prev;
    cnt_inc    = cnt + CW'(1'b1);
    sp_inc     = score_p + 4'd1;
    sa_inc     = score_ai + 4'd1;
    nxt        = cur;
    cnt_nxt    = cnt;
    sp_nxt     = score_p;
    sa_nxt     = score_ai;
    dir_nxt    = serve_dir;
    missed_nxt = 1'b0;
    win_nxt    = winner;
    case (cur)
      S_IDLE, S_OVER: begin
        if (start_det) begin
          nxt     = S_CENTRE;
          sp_nxt  = 4'd0;
          sa_nxt  = 4'd0;
          win_nxt = 1'b0;
        end else begin
          nxt = cur;
        end
      end
      S_CENTRE: begin
        nxt     = S_SERVE_WAIT;
        cnt_nxt = {CW{1'b0}};
      end
      S_SERVE_WAIT: begin
        if (frame_tick) begin
          cnt_nxt = cnt_inc;
          nxt     = (cnt_inc == SERVE_CNT) ? S_RALLY : S_SERVE_WAIT;
        end else begin
          nxt = S_SERVE_WAIT;
        end
      end
      S_RALLY: begin
        // miss_left has priority when both edges report a miss together
        if (miss_left) begin
          sa_nxt     = sa_inc;
          missed_nxt = 1'b1;
          dir_nxt    = 1'b0;
          cnt_nxt    = {CW{1'b0}};
          if (sa_inc == WIN_CNT) begin
            nxt     = S_OVER;
            win_nxt = 1'b1;
          end else begin
            nxt = S_POINT;
          end
        end else if (miss_right) begin
          sp_nxt     = sp_inc;
          missed_nxt = 1'b1;
          dir_nxt    = 1'b1;
          cnt_nxt    = {CW{1'b0}};
          if (sp_inc == WIN_CNT) begin
            nxt     = S_OVER;
            win_nxt = 1'b0;
          end else begin
            nxt = S_POINT;
          end
        end else begin
          nxt = S_RALLY;
        end
      end
      S_POINT: begin
        if (frame_tick) begin
          cnt_nxt = cnt_inc;
          nxt     = (cnt_inc == PAUSE_CNT) ? S_CENTRE : S_POINT;
        end else begin
          nxt = S_POINT;
        end
      end
      default: begin
        nxt = S_IDLE;
      end
    endcase
    serve_nxt = (nxt == S_RALLY) && (cur != S_RALLY);
    rg_nxt    = !((nxt == S_RALLY) || (nxt == S_POINT));
    go_nxt    = (nxt == S_OVER);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk_0) begin
    if (rst) begin
      cur        <= S_IDLE;
      cnt        <= {CW{1'b0}};
      start_prev <= 1'b1;
      score_p    <= 4'd0;
      score_ai   <= 4'd0;
      serve      <= 1'b0;
      sq_missed  <= 1'b0;
      reset_game <= 1'b1;
      game_over  <= 1'b0;
      winner     <= 1'b0;
      serve_dir  <= 1'b1;
    end else begin
      cur        <= nxt;
      cnt        <= cnt_nxt;
      start_prev <= start_btn;
      score_p    <= sp_nxt;
      score_ai   <= sa_nxt;
      serve      <= serve_nxt;
      sq_missed  <= missed_nxt;
      reset_game <= rg_nxt;
      game_over  <= go_nxt;
      winner     <= win_nxt;
      serve_dir  <= dir_nxt;
    end
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed scoreboard bench for pong_match_ctrl with WIN_SCORE=3,
// SERVE_FRAMES=2, PAUSE_FRAMES=3.
module tb_pong_match_ctrl;

  localparam logic [2:0] IDLE = 3'd0, CENTRE = 3'd1, SW = 3'd2,
                         RALLY = 3'd3, POINT = 3'd4, OVER = 3'd5;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] sp;
    logic [3:0] sa;
    logic       rg;
    logic       sv;
    logic       dir;
    logic       sm;
    logic       go;
    logic       win;
  } obs_t;

  logic       clk_0 = 1'b0;
  logic       rst = 1'b1, start_btn = 1'b0, frame_tick = 1'b0;
  logic       miss_left = 1'b0, miss_right = 1'b0;
  logic       reset_game, serve, serve_dir, sq_missed, game_over, winner;
  logic [3:0] score_p, score_ai;
  logic [2:0] state;

  obs_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] m_sp = 4'd0, m_sa = 4'd0;
  logic       m_dir = 1'b1, m_win = 1'b0;

  always #5 clk_0 = ~clk_0;

  pong_match_ctrl #(.WIN_SCORE(3), .SERVE_FRAMES(2), .PAUSE_FRAMES(3)) dut (
    .clk_0(clk_0), .rst(rst), .start_btn(start_btn), .frame_tick(frame_tick),
    .miss_left(miss_left), .miss_right(miss_right), .reset_game(reset_game),
    .serve(serve), .serve_dir(serve_dir), .sq_missed(sq_missed),
    .score_p(score_p), .score_ai(score_ai), .game_over(game_over),
    .winner(winner), .state(state)
  );

  // Drive one cycle of inputs, queue the expected outputs, then compare after the edge.
  task automatic step(input string tag, input logic r, sb, ft, ml, mr,
                      input logic [2:0] st, input logic sv, sm);
    obs_t e, o;
    rst = r; start_btn = sb; frame_tick = ft; miss_left = ml; miss_right = mr;
    e.st  = st;
    e.sp  = m_sp;
    e.sa  = m_sa;
    e.rg  = (st == IDLE) || (st == CENTRE) || (st == SW) || (st == OVER);
    e.sv  = sv;
    e.dir = m_dir;
    e.sm  = sm;
    e.go  = (st == OVER);
    e.win = m_win;
    sb_q.push_back(e);
    @(posedge clk_0);
    #1;
    o = {state, score_p, score_ai, reset_game, serve, serve_dir, sq_missed, game_over, winner};
    e = sb_q.pop_front();
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Pause after a point, recentre, count down the serve and launch again.
  task automatic to_rally();
    step("pause1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, POINT, 1'b0, 1'b0);
    step("pause2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, POINT, 1'b0, 1'b0);
    step("pause3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, CENTRE, 1'b0, 1'b0);
    step("recentre", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SW, 1'b0, 1'b0);
    step("sw_tick1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, SW, 1'b0, 1'b0);
    step("reserve", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, RALLY, 1'b1, 1'b0);
  endtask

  initial begin
    step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0);
    step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0);
    step("start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CENTRE, 1'b0, 1'b0);
    step("centre_tick_ignored", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, SW, 1'b0, 1'b0);
    step("sw_no_tick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SW, 1'b0, 1'b0);
    step("sw_tick1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, SW, 1'b0, 1'b0);
    step("serve", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, RALLY, 1'b1, 1'b0);
    step("rally_hold", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, RALLY, 1'b0, 1'b0);

    m_sp = 4'd1; m_dir = 1'b1;
    step("miss_right", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, POINT, 1'b0, 1'b1);
    step("point_miss_ignored", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, POINT, 1'b0, 1'b0);
    step("point_tick2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, POINT, 1'b0, 1'b0);
    step("point_tick3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, CENTRE, 1'b0, 1'b0);
    step("centre2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, SW, 1'b0, 1'b0);
    step("sw2_tick1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, SW, 1'b0, 1'b0);
    step("serve2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, RALLY, 1'b1, 1'b0);

    m_sa = 4'd1; m_dir = 1'b0;
    step("both_miss", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, POINT, 1'b0, 1'b1);
    to_rally();
    m_sa = 4'd2;
    step("miss_left2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, POINT, 1'b0, 1'b1);
    to_rally();
    m_sa = 4'd3; m_win = 1'b1;
    step("ai_wins", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, OVER, 1'b0, 1'b1);
    step("over_miss_ignored", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, OVER, 1'b0, 1'b0);
    step("over_btn_low", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OVER, 1'b0, 1'b0);

    m_sp = 4'd0; m_sa = 4'd0; m_win = 1'b0;
    step("restart", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CENTRE, 1'b0, 1'b0);
    step("restart_sw", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SW, 1'b0, 1'b0);
    step("restart_tick1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, SW, 1'b0, 1'b0);
    step("restart_serve", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, RALLY, 1'b1, 1'b0);

    m_dir = 1'b1;
    step("rst_mid_rally", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, IDLE, 1'b0, 1'b0);
    step("held_no_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0);
    step("btn_low", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0);
    step("restart2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CENTRE, 1'b0, 1'b0);
    step("r2_sw", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SW, 1'b0, 1'b0);
    step("r2_tick1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, SW, 1'b0, 1'b0);
    step("r2_serve", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, RALLY, 1'b1, 1'b0);

    m_sp = 4'd1;
    step("r2_miss_right", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, POINT, 1'b0, 1'b1);
    step("r2_pause", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, POINT, 1'b0, 1'b0);
    m_sp = 4'd0;
    step("rst_mid_point", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, IDLE, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
